// File: rtl/simd_wave_sequencer.sv
// -----------------------------------------------------------------------------
// simd_wave_sequencer
//
// Per-SIMD control sequencer. It steps one dispatched wavefront through every
// lane group (wave cycle) of each instruction. It also drives the shared
// simd_state seen by the PC, fetcher, decoder, register files, ALUs and LSUs.
// It owns the wave PC, produces a registered per-cycle active-lane mask and
// reports wave completion to the dispatcher.
//
// Parameters:
//   LANE_WIDTH             physical lanes per SIMD
//   WAVE_SIZE              threads per wavefront (>= 1, any value)
//   PROGRAM_MEM_ADDR_WIDTH PC width
//
// Ports:
//   clk, rst (async, active-high)
//   enable            low => every register holds and inputs are ignored
//   simd_start        dispatch pulse, honoured only in IDLE or DONE
//   block_id, wave_id, block_dim, num_threads  thread-indexing inputs (32b)
//   fetch_done        fetcher has a valid instruction
//   is_mem            decoded op is a load/store (latched in REQUEST)
//   is_ret            decoded op is RET (sampled in UPDATE)
//   lsu_done          per-lane LSU completion
//   simd_state        FSM state (IDLE..DONE = 0..7), also the debug view
//   curr_wave_cycle   current lane group
//   lane_mask         active lanes of the current lane group (registered)
//   pc                wave program counter
//   simd_done         wave finished (level)
//   busy              high in every state except IDLE and DONE
//   instr_count, stall_count  perf counters, present only with
//                     SIMD_PERF_CNT_EN defined
//
// Optional feature macro: SIMD_PERF_CNT_EN
//
// Handshakes: fetch_done and lsu_done are level "ready" indications. The
// sequencer advances out of FETCH in any cycle where fetch_done is high. It
// advances out of WAIT in any cycle where every lane of lane_mask has its
// lsu_done bit high. Both inputs are only looked at while enable is high.
// -----------------------------------------------------------------------------
module simd_wave_sequencer #(
    parameter int LANE_WIDTH             = 16,
    parameter int WAVE_SIZE              = 32,
    parameter int PROGRAM_MEM_ADDR_WIDTH = 6,
    localparam int TOTAL_WAVE_CYCLES     = (WAVE_SIZE + LANE_WIDTH - 1) / LANE_WIDTH,
    localparam int CYCLE_W               = (TOTAL_WAVE_CYCLES > 1) ? $clog2(TOTAL_WAVE_CYCLES) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              enable,
    input  logic                              simd_start,
    input  logic [31:0]                       block_id,
    input  logic [31:0]                       wave_id,
    input  logic [31:0]                       block_dim,
    input  logic [31:0]                       num_threads,
    input  logic                              fetch_done,
    input  logic                              is_mem,
    input  logic                              is_ret,
    input  logic [LANE_WIDTH-1:0]             lsu_done,
    output logic [2:0]                        simd_state,
    output logic [CYCLE_W-1:0]                curr_wave_cycle,
    output logic [LANE_WIDTH-1:0]             lane_mask,
    output logic [PROGRAM_MEM_ADDR_WIDTH-1:0] pc,
    output logic                              simd_done,
`ifdef SIMD_PERF_CNT_EN
    output logic [31:0]                       instr_count,
    output logic [31:0]                       stall_count,
`endif
    output logic                              busy
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_REQUEST = 3'd3,
        S_WAIT    = 3'd4,
        S_EXECUTE = 3'd5,
        S_UPDATE  = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    // Active lanes of lane group 'cyc'. t_base = wave_id*WAVE_SIZE and
    // g_base = block_id*block_dim, so t = t_base + lidx and g = g_base + t.
    // All arithmetic wraps at 32 bits.
    function automatic logic [LANE_WIDTH-1:0] calc_mask(
        input logic [31:0] cyc,
        input logic [31:0] t_base,
        input logic [31:0] g_base,
        input logic [31:0] bdim,
        input logic [31:0] nthr
    );
        logic [31:0] lidx;
        logic [31:0] t;
        logic [31:0] g;
        calc_mask = '0;
        for (int i = 0; i < LANE_WIDTH; i++) begin
            lidx = cyc * 32'(LANE_WIDTH) + 32'(i);
            t    = t_base + lidx;
            g    = g_base + t;
            calc_mask[i] = (lidx < 32'(WAVE_SIZE)) && (t < bdim) && (g < nthr);
        end
    endfunction

    state_t                            state_q, state_d;
    logic [PROGRAM_MEM_ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [CYCLE_W-1:0]                cyc_q, cyc_d;
    logic [LANE_WIDTH-1:0]             mask_q, mask_d;
    logic                              done_q, done_d;
    logic                              is_mem_q, is_mem_d;
    // Indexing inputs captured at dispatch so later lane groups use the same
    // wave description even if the dispatcher moves on.
    logic [31:0]                       t_base_q, t_base_d;
    logic [31:0]                       g_base_q, g_base_d;
    logic [31:0]                       bdim_q, bdim_d;
    logic [31:0]                       nthr_q, nthr_d;
`ifdef SIMD_PERF_CNT_EN
    logic [31:0]                       instr_cnt_q, instr_cnt_d;
    logic [31:0]                       stall_cnt_q, stall_cnt_d;
`endif

    logic [LANE_WIDTH-1:0] start_mask;   // cycle-0 mask from live inputs
    logic [LANE_WIDTH-1:0] next_mask;    // mask of lane group cyc_q+1
    logic [LANE_WIDTH-1:0] first_mask;   // cycle-0 mask from captured inputs
    logic                  more_cycles;
    logic                  advance;
    logic                  wait_ok;

    always_comb begin
        start_mask  = calc_mask(32'd0, wave_id * 32'(WAVE_SIZE), block_id * block_dim,
                                block_dim, num_threads);
        next_mask   = calc_mask(32'(cyc_q) + 32'd1, t_base_q, g_base_q, bdim_q, nthr_q);
        first_mask  = calc_mask(32'd0, t_base_q, g_base_q, bdim_q, nthr_q);
        more_cycles = 32'(cyc_q) < 32'(TOTAL_WAVE_CYCLES - 1);
        // A trailing lane group with no live threads is skipped entirely.
        advance     = more_cycles && (next_mask != '0);
        // Inactive lanes never issue, so their lsu_done bits are don't-care.
        wait_ok     = !is_mem_q || ((lsu_done & mask_q) == mask_q);
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (enable) begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (simd_start) begin
                        state_d = (start_mask == '0) ? S_DONE : S_FETCH;
                    end
                end
                S_FETCH:   if (fetch_done) state_d = S_DECODE;
                S_DECODE:  state_d = S_REQUEST;
                S_REQUEST: state_d = S_WAIT;
                S_WAIT:    if (wait_ok) state_d = S_EXECUTE;
                S_EXECUTE: state_d = S_UPDATE;
                S_UPDATE: begin
                    if (advance) begin
                        state_d = S_REQUEST;
                    end else if (is_ret) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
                default:   state_d = S_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy            = (state_q != S_IDLE) && (state_q != S_DONE);
        simd_state      = state_q;
        curr_wave_cycle = cyc_q;
        lane_mask       = mask_q;
        pc              = pc_q;
        simd_done       = done_q;
    end

`ifdef SIMD_PERF_CNT_EN
    assign instr_count = instr_cnt_q;
    assign stall_count = stall_cnt_q;
`endif

    // ---------------- Datapath next values ----------------
    always_comb begin
        pc_d     = pc_q;
        cyc_d    = cyc_q;
        mask_d   = mask_q;
        done_d   = done_q;
        is_mem_d = is_mem_q;
        t_base_d = t_base_q;
        g_base_d = g_base_q;
        bdim_d   = bdim_q;
        nthr_d   = nthr_q;
`ifdef SIMD_PERF_CNT_EN
        instr_cnt_d = instr_cnt_q;
        stall_cnt_d = stall_cnt_q;
`endif
        if (enable) begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (simd_start) begin
                        pc_d     = '0;
                        cyc_d    = '0;
                        mask_d   = start_mask;
                        // An empty wave completes immediately.
                        done_d   = (start_mask == '0);
                        t_base_d = wave_id * 32'(WAVE_SIZE);
                        g_base_d = block_id * block_dim;
                        bdim_d   = block_dim;
                        nthr_d   = num_threads;
`ifdef SIMD_PERF_CNT_EN
                        instr_cnt_d = '0;
                        stall_cnt_d = '0;
`endif
                    end
                end
                S_REQUEST: is_mem_d = is_mem;
                S_WAIT: begin
`ifdef SIMD_PERF_CNT_EN
                    if (!wait_ok && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                        stall_cnt_d = stall_cnt_q + 32'd1;
                    end
`endif
                end
                S_UPDATE: begin
                    if (advance) begin
                        cyc_d  = cyc_q + 1'b1;
                        mask_d = next_mask;
                    end else begin
                        // Back to lane group 0 for the next instruction.
                        cyc_d  = '0;
                        mask_d = first_mask;
                        if (is_ret) begin
                            done_d = 1'b1;
                        end else begin
                            pc_d = pc_q + 1'b1;
                        end
`ifdef SIMD_PERF_CNT_EN
                        if (instr_cnt_q != 32'hFFFF_FFFF) begin
                            instr_cnt_d = instr_cnt_q + 32'd1;
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= '0;
            cyc_q    <= '0;
            mask_q   <= '0;
            done_q   <= 1'b0;
            is_mem_q <= 1'b0;
            t_base_q <= '0;
            g_base_q <= '0;
            bdim_q   <= '0;
            nthr_q   <= '0;
`ifdef SIMD_PERF_CNT_EN
            instr_cnt_q <= '0;
            stall_cnt_q <= '0;
`endif
        end else begin
            pc_q     <= pc_d;
            cyc_q    <= cyc_d;
            mask_q   <= mask_d;
            done_q   <= done_d;
            is_mem_q <= is_mem_d;
            t_base_q <= t_base_d;
            g_base_q <= g_base_d;
            bdim_q   <= bdim_d;
            nthr_q   <= nthr_d;
`ifdef SIMD_PERF_CNT_EN
            instr_cnt_q <= instr_cnt_d;
            stall_cnt_q <= stall_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_simd_wave_sequencer.sv
`timescale 1ns/1ps
module tb_simd_wave_sequencer;

    localparam int TRACE_W = 5;   // {pc[0], curr_wave_cycle[0], simd_state}

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_FETCH   = 3'd1;
    localparam logic [2:0] ST_DECODE  = 3'd2;
    localparam logic [2:0] ST_WAIT    = 3'd4;
    localparam logic [2:0] ST_EXECUTE = 3'd5;
    localparam logic [2:0] ST_UPDATE  = 3'd6;
    localparam logic [2:0] ST_DONE    = 3'd7;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        simd_start;
    logic [31:0] block_id, wave_id, block_dim, num_threads;
    logic        fetch_done, is_mem, is_ret;
    logic [15:0] lsu_done;

    // Default instance (WAVE_SIZE=32)
    logic [2:0]  simd_state;
    logic [0:0]  curr_wave_cycle;
    logic [15:0] lane_mask;
    logic [5:0]  pc;
    logic        simd_done, busy;
    // Partial-wave instance (WAVE_SIZE=20)
    logic [2:0]  simd_state_b;
    logic [0:0]  curr_wave_cycle_b;
    logic [15:0] lane_mask_b;
    logic [5:0]  pc_b;
    logic        simd_done_b, busy_b;
`ifdef SIMD_PERF_CNT_EN
    logic [31:0] instr_count, stall_count, instr_count_b, stall_count_b;
`endif

    int assert_count = 0;
    int fail_count   = 0;
    logic [TRACE_W-1:0] exp_q[$];
    logic [2:0] st_tab [10] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd3, 3'd4, 3'd5, 3'd6};

    simd_wave_sequencer #(.LANE_WIDTH(16), .WAVE_SIZE(32), .PROGRAM_MEM_ADDR_WIDTH(6)) dut (
        .clk(clk), .rst(rst), .enable(enable), .simd_start(simd_start),
        .block_id(block_id), .wave_id(wave_id), .block_dim(block_dim), .num_threads(num_threads),
        .fetch_done(fetch_done), .is_mem(is_mem), .is_ret(is_ret), .lsu_done(lsu_done),
        .simd_state(simd_state), .curr_wave_cycle(curr_wave_cycle), .lane_mask(lane_mask),
        .pc(pc), .simd_done(simd_done),
`ifdef SIMD_PERF_CNT_EN
        .instr_count(instr_count), .stall_count(stall_count),
`endif
        .busy(busy)
    );

    simd_wave_sequencer #(.LANE_WIDTH(16), .WAVE_SIZE(20), .PROGRAM_MEM_ADDR_WIDTH(6)) dut20 (
        .clk(clk), .rst(rst), .enable(enable), .simd_start(simd_start),
        .block_id(block_id), .wave_id(wave_id), .block_dim(block_dim), .num_threads(num_threads),
        .fetch_done(fetch_done), .is_mem(is_mem), .is_ret(is_ret), .lsu_done(lsu_done),
        .simd_state(simd_state_b), .curr_wave_cycle(curr_wave_cycle_b), .lane_mask(lane_mask_b),
        .pc(pc_b), .simd_done(simd_done_b),
`ifdef SIMD_PERF_CNT_EN
        .instr_count(instr_count_b), .stall_count(stall_count_b),
`endif
        .busy(busy_b)
    );

    // ---------------- Clock ----------------
    always #5 clk = ~clk;

    // ---------------- Driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_wave();
        simd_start = 1'b1;
        step();
        simd_start = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert_count++;
        assert (obs === exp) else begin
            fail_count++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] target, input string tag);
        int n;
        n = 0;
        while (simd_state !== target && n < 50) begin
            step();
            n++;
        end
        check(tag, 32'(simd_state), 32'(target));
    endtask

    // ---------------- Directed sequence ----------------
    initial begin
        rst = 1'b1; enable = 1'b1; simd_start = 1'b0;
        block_id = 0; wave_id = 0; block_dim = 32; num_threads = 32;
        fetch_done = 1'b1; is_mem = 1'b0; is_ret = 1'b0; lsu_done = '0;
        step();
        step();

        // Reset values
        check("rst_state", 32'(simd_state), 0);
        check("rst_pc", 32'(pc), 0);
        check("rst_cyc", 32'(curr_wave_cycle), 0);
        check("rst_mask", 32'(lane_mask), 0);
        check("rst_done", 32'(simd_done), 0);
        check("rst_busy", 32'(busy), 0);
`ifdef SIMD_PERF_CNT_EN
        check("rst_icnt", instr_count, 0);
        check("rst_scnt", stall_count, 0);
`endif
        rst = 1'b0;
        step();

        // Two non-memory instructions, the second a RET, full 32-thread wave
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 10; k++) begin
                exp_q.push_back({p[0], (k >= 6) ? 1'b1 : 1'b0, st_tab[k]});
            end
        end
        exp_q.push_back({1'b1, 1'b0, ST_DONE});

        start_wave();
        for (int k = 0; k < 21; k++) begin
            if (k > 0) step();
            check($sformatf("a_trace%0d", k), {pc[0], curr_wave_cycle[0], simd_state}, exp_q.pop_front());
            if (k == 0) begin
                check("a_busy", 32'(busy), 1);
                check("a_mask0", 32'(lane_mask), 32'hFFFF);
                check("a_mask0_ws20", 32'(lane_mask_b), 32'hFFFF);
            end
            if (k == 6) begin
                check("a_mask1", 32'(lane_mask), 32'hFFFF);
                check("a_mask1_ws20", 32'(lane_mask_b), 32'h000F);
                check("a_cyc1_ws20", 32'(curr_wave_cycle_b), 1);
            end
            if (k == 10) begin
                check("a_pc1", 32'(pc), 1);
                is_ret = 1'b1;
            end
            if (k == 20) begin
                check("a_done", 32'(simd_done), 1);
                check("a_busy_done", 32'(busy), 0);
                check("a_pc_done", 32'(pc), 1);
                check("a_state_ws20", 32'(simd_state_b), 32'(ST_DONE));
                check("a_done_ws20", 32'(simd_done_b), 1);
                check("a_busy_ws20", 32'(busy_b), 0);
                check("a_pc_ws20", 32'(pc_b), 1);
            end
        end
        step();
        step();
        check("a_done_hold", 32'(simd_done), 1);
        check("a_state_hold", 32'(simd_state), 32'(ST_DONE));

        // Partial block: 20 threads, memory op with a 7-cycle LSU stall
        num_threads = 20; is_mem = 1'b1; is_ret = 1'b1; lsu_done = '0;
        start_wave();
        check("b_fetch", 32'(simd_state), 32'(ST_FETCH));
        check("b_done_clr", 32'(simd_done), 0);
        check("b_mask0", 32'(lane_mask), 32'hFFFF);
        wait_state(ST_WAIT, "b_wait0");
        check("b_cyc0", 32'(curr_wave_cycle), 0);
        for (int k = 0; k < 7; k++) begin
            simd_start = (k == 0);   // must be ignored while busy
            step();
            simd_start = 1'b0;
            check($sformatf("b_stall%0d", k), 32'(simd_state), 32'(ST_WAIT));
        end
`ifdef SIMD_PERF_CNT_EN
        check("b_scnt7", stall_count, 7);
`endif
        lsu_done = 16'hFFFF;
        step();
        check("b_exec0", 32'(simd_state), 32'(ST_EXECUTE));
        lsu_done = '0;
        wait_state(ST_WAIT, "b_wait1");
        check("b_cyc1", 32'(curr_wave_cycle), 1);
        check("b_mask1", 32'(lane_mask), 32'h000F);
        lsu_done = 16'hFFF7;         // lane 3 missing
        step();
        check("b_lane3_stall", 32'(simd_state), 32'(ST_WAIT));
        lsu_done = 16'h000F;         // only active lanes complete
        step();
        check("b_exec1", 32'(simd_state), 32'(ST_EXECUTE));
        step();
        check("b_update1", 32'(simd_state), 32'(ST_UPDATE));
        step();
        check("b_state_done", 32'(simd_state), 32'(ST_DONE));
        check("b_done", 32'(simd_done), 1);
        check("b_busy", 32'(busy), 0);
        check("b_pc", 32'(pc), 0);
`ifdef SIMD_PERF_CNT_EN
        check("b_icnt", instr_count, 1);
        check("b_scnt", stall_count, 8);
        check("b_icnt_ws20", instr_count_b, 1);
        check("b_scnt_ws20", stall_count_b, 8);
`endif

        // Reset during WAIT, simultaneous start+reset, restart, enable hold
        num_threads = 32; is_mem = 1'b0; is_ret = 1'b0; lsu_done = '0;
        start_wave();
        repeat (10) step();
        check("e_fetch_pc1", {27'd0, pc[0], 1'b0, simd_state}, {27'd0, 1'b1, 1'b0, ST_FETCH});
        is_mem = 1'b1;
        wait_state(ST_WAIT, "e_wait");
        #2;
        rst = 1'b1;
        #1;
        check("e_rst_state", 32'(simd_state), 32'(ST_IDLE));
        check("e_rst_pc", 32'(pc), 0);
        check("e_rst_cyc", 32'(curr_wave_cycle), 0);
        check("e_rst_mask", 32'(lane_mask), 0);
        check("e_rst_done", 32'(simd_done), 0);
        check("e_rst_busy", 32'(busy), 0);
        simd_start = 1'b1;
        step();
        simd_start = 1'b0;
        check("e_rst_wins", 32'(simd_state), 32'(ST_IDLE));
        rst = 1'b0; is_mem = 1'b0;
        start_wave();
        check("e_restart", 32'(simd_state), 32'(ST_FETCH));
        check("e_restart_pc", 32'(pc), 0);
        enable = 1'b0;
        repeat (3) step();
        check("e_en_hold", 32'(simd_state), 32'(ST_FETCH));
        enable = 1'b1;
        step();
        check("e_en_resume", 32'(simd_state), 32'(ST_DECODE));

        // Empty wave straight from IDLE
        rst = 1'b1;
        step();
        rst = 1'b0;
        num_threads = 10; wave_id = 1; block_dim = 64; block_id = 0;
        check("c_idle", 32'(simd_state), 32'(ST_IDLE));
        start_wave();
        check("c_state", 32'(simd_state), 32'(ST_DONE));
        check("c_done", 32'(simd_done), 1);
        check("c_busy", 32'(busy), 0);
        check("c_mask", 32'(lane_mask), 0);
        check("c_state_ws20", 32'(simd_state_b), 32'(ST_DONE));

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
